// File: rtl/life_rand_fill.sv
// Random board-fill generator: a Fibonacci LFSR produces one cell per cycle at a
// programmable live density; finished rows are offered over valid/ready.
module life_rand_fill #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'h0339,
  parameter int                ROW_W  = 32,
  parameter int                ROWS   = 32,
  localparam int               IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [4:0]        density,
  output logic              busy,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [ROW_W-1:0]  row_data,
  output logic [IDX_W-1:0]  row_idx,
  output logic              done
);

  localparam int CNT_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_OFFER,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [LFSR_W-1:0]  lfsr;
  logic [4:0]         density_q;
  logic [CNT_W-1:0]   cell_cnt;
  logic               fb;
  logic               cell_bit;
  logic               last_cell;
  logic               last_row;

  assign fb        = ^(lfsr & TAPS);
  assign cell_bit  = ({1'b0, lfsr[3:0]} < density_q);
  assign last_cell = (cell_cnt == CNT_W'(ROW_W - 1));
  assign last_row  = (row_idx == IDX_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    row_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        // seed_load takes priority: a concurrent start is dropped.
        if (start && !seed_load) state_nxt = S_FILL;
      end
      S_FILL: begin
        busy = 1'b1;
        if (abort)          state_nxt = S_IDLE;
        else if (last_cell) state_nxt = S_OFFER;
      end
      S_OFFER: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        if (abort)          state_nxt = S_IDLE;
        else if (row_ready) state_nxt = last_row ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= SEED;
      density_q <= '0;
      cell_cnt  <= '0;
      row_data  <= '0;
      row_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED : seed_in;
          end else if (start) begin
            density_q <= density;
            cell_cnt  <= '0;
            row_idx   <= '0;
          end
        end
        S_FILL: begin
          if (!abort) begin
            row_data[cell_cnt] <= cell_bit;
            lfsr               <= {lfsr[LFSR_W-2:0], fb};
            cell_cnt           <= cell_cnt + 1'b1;
          end
        end
        S_OFFER: begin
          if (!abort && row_ready && !last_row) begin
            row_idx  <= row_idx + 1'b1;
            cell_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
